soc_system: RTL and testbench

- Small peripheral SoC top built around a PS/2 keyboard receiver, an 8N1 UART (RX and TX), a 4-digit multiplexed 7-segment driver and a heartbeat LED.
- Keyboard make codes are translated to ASCII and presented on `ascii`.
- Every translated key and every UART-received byte is transmitted on `uart_txd`.
- The last UART byte and the last key are shown in hex on the display.

---
 rtl/soc_system.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_soc_system.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system.sv
`timescale 1ns / 1ps
// Peripheral SoC top: PS/2 keyboard to ASCII, 8N1 UART RX/TX echo, 4-digit hex display
// and a 1 Hz heartbeat LED.
module soc_system #(
  parameter int unsigned clk_freq       = 50000000,
  parameter int unsigned uart_baud_rate = 115200
) (
  input  logic       clk,
  input  logic       rst,
  output logic       led,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [7:0] ascii,
  input  logic       clkps2,
  input  logic       ps2_dat_in,
  output logic [3:0] an_out,
  output logic [7:0] seg_out
);

  localparam int unsigned Div     = clk_freq / uart_baud_rate;
  localparam int unsigned HalfSec = clk_freq / 2;
  localparam int unsigned PsTout  = clk_freq / 10000;
  localparam int unsigned RefDiv  = clk_freq / 1000;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

  // Set-2 make code to ASCII; bit 8 flags a mapped code.
  function automatic logic [8:0] xlate(input logic [7:0] sc);
    case (sc)
      8'h1C: xlate = 9'h161; 8'h32: xlate = 9'h162; 8'h21: xlate = 9'h163; 8'h23: xlate = 9'h164;
      8'h24: xlate = 9'h165; 8'h2B: xlate = 9'h166; 8'h34: xlate = 9'h167; 8'h33: xlate = 9'h168;
      8'h43: xlate = 9'h169; 8'h3B: xlate = 9'h16A; 8'h42: xlate = 9'h16B; 8'h4B: xlate = 9'h16C;
      8'h3A: xlate = 9'h16D; 8'h31: xlate = 9'h16E; 8'h44: xlate = 9'h16F; 8'h4D: xlate = 9'h170;
      8'h15: xlate = 9'h171; 8'h2D: xlate = 9'h172; 8'h1B: xlate = 9'h173; 8'h2C: xlate = 9'h174;
      8'h3C: xlate = 9'h175; 8'h2A: xlate = 9'h176; 8'h1D: xlate = 9'h177; 8'h22: xlate = 9'h178;
      8'h35: xlate = 9'h179; 8'h1A: xlate = 9'h17A;
      8'h45: xlate = 9'h130; 8'h16: xlate = 9'h131; 8'h1E: xlate = 9'h132; 8'h26: xlate = 9'h133;
      8'h25: xlate = 9'h134; 8'h2E: xlate = 9'h135; 8'h36: xlate = 9'h136; 8'h3D: xlate = 9'h137;
      8'h3E: xlate = 9'h138; 8'h46: xlate = 9'h139;
      8'h29: xlate = 9'h120; 8'h5A: xlate = 9'h10D;
      default: xlate = 9'h000;
    endcase
  endfunction

  function automatic logic [7:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 8'hC0; 4'h1: font = 8'hF9; 4'h2: font = 8'hA4; 4'h3: font = 8'hB0;
      4'h4: font = 8'h99; 4'h5: font = 8'h92; 4'h6: font = 8'h82; 4'h7: font = 8'hF8;
      4'h8: font = 8'h80; 4'h9: font = 8'h90; 4'hA: font = 8'h88; 4'hB: font = 8'h83;
      4'hC: font = 8'hC6; 4'hD: font = 8'hA1; 4'hE: font = 8'h86; default: font = 8'h8E;
    endcase
  endfunction

  logic [31:0] hb_cnt_q, ref_cnt_q;
  logic        led_q;
  logic [1:0]  ps2c_sync_q, ps2d_sync_q, rxd_sync_q, dig_q;
  logic        ps2c_prev_q, rxd_prev_q, ps2_fall, rxd_fall;
  logic [3:0]  an_q, an_d, nib;
  logic [7:0]  seg_q, seg_d;

  assign ps2_fall = ps2c_prev_q & ~ps2c_sync_q[1];
  assign rxd_fall = rxd_prev_q & ~rxd_sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_cnt_q    <= '0;
      led_q       <= 1'b0;
      ps2c_sync_q <= 2'b11;
      ps2d_sync_q <= 2'b11;
      rxd_sync_q  <= 2'b11;
      ps2c_prev_q <= 1'b1;
      rxd_prev_q  <= 1'b1;
      ref_cnt_q   <= '0;
      dig_q       <= '0;
      an_q        <= 4'b1110;
      seg_q       <= 8'hC0;
    end else begin
      if (hb_cnt_q == HalfSec - 1) begin
        hb_cnt_q <= '0;
        led_q    <= ~led_q;
      end else begin
        hb_cnt_q <= hb_cnt_q + 32'd1;
      end
      ps2c_sync_q <= {ps2c_sync_q[0], clkps2};
      ps2d_sync_q <= {ps2d_sync_q[0], ps2_dat_in};
      rxd_sync_q  <= {rxd_sync_q[0], uart_rxd};
      ps2c_prev_q <= ps2c_sync_q[1];
      rxd_prev_q  <= rxd_sync_q[1];
      if (ref_cnt_q == RefDiv - 1) begin
        ref_cnt_q <= '0;
        dig_q     <= dig_q + 2'd1;
      end else begin
        ref_cnt_q <= ref_cnt_q + 32'd1;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  // PS/2 frame assembly; the 11th bit is combined with the 10 stored ones.
  logic [9:0]  ps2_sr_q, ps2_sr_d;
  logic [10:0] frame;
  logic [3:0]  ps2_bits_q, ps2_bits_d;
  logic [31:0] ps2_tout_q, ps2_tout_d;
  logic [7:0]  code_q, code_d;
  logic        code_vld_q, code_vld_d;

  assign frame = {ps2d_sync_q[1], ps2_sr_q};

  always_comb begin
    ps2_sr_d   = ps2_sr_q;
    ps2_bits_d = ps2_bits_q;
    ps2_tout_d = '0;
    code_d     = code_q;
    code_vld_d = 1'b0;
    if (ps2_fall) begin
      if (ps2_bits_q == 4'd10) begin
        ps2_bits_d = '0;
        code_d     = frame[8:1];
        code_vld_d = ~frame[0] & frame[10] & (^frame[9:1]);
      end else begin
        ps2_sr_d   = {ps2d_sync_q[1], ps2_sr_q[9:1]};
        ps2_bits_d = ps2_bits_q + 4'd1;
      end
    end else if (ps2_bits_q != 4'd0) begin
      if (ps2_tout_q == PsTout - 1) ps2_bits_d = '0;
      else ps2_tout_d = ps2_tout_q + 32'd1;
    end
  end

  rx_state_e   rx_state_q, rx_state_d;
  logic [31:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_done;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 32'd1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rxd_fall) rx_state_d = RxStart;
      end
      RxStart: if (rx_cnt_q == Div / 2 - 1) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rxd_sync_q[1] ? RxIdle : RxData;
      end
      RxData: if (rx_cnt_q == Div - 1) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rxd_sync_q[1], rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RxStop;
      end
      RxStop: if (rx_cnt_q == Div - 1) begin
        rx_done    = rxd_sync_q[1];
        rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  tx_state_e   tx_state_q, tx_state_d;
  logic [31:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d, key_q, key_d, rx_byte_q, rx_byte_d;
  logic        txd_q, txd_d, brk_q, brk_d, kb_pend_q, kb_pend_d, rx_pend_q, rx_pend_d;
  logic [8:0]  xl;

  assign xl = xlate(code_q);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 32'd1;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    kb_pend_d  = kb_pend_q;
    rx_pend_d  = rx_pend_q;
    brk_d      = brk_q;
    key_d      = key_q;
    rx_byte_d  = rx_byte_q;
    case (tx_state_q)
      TxIdle: begin
        tx_cnt_d = '0;
        if (kb_pend_q) begin
          tx_sh_d    = key_q;
          kb_pend_d  = 1'b0;
          txd_d      = 1'b0;
          tx_state_d = TxStart;
        end else if (rx_pend_q) begin
          tx_sh_d    = rx_byte_q;
          rx_pend_d  = 1'b0;
          txd_d      = 1'b0;
          tx_state_d = TxStart;
        end
      end
      TxStart: if (tx_cnt_q == Div - 1) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        txd_d      = tx_sh_q[0];
        tx_state_d = TxData;
      end
      TxData: if (tx_cnt_q == Div - 1) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          txd_d      = 1'b1;
          tx_state_d = TxStop;
        end else begin
          tx_bit_d = tx_bit_q + 3'd1;
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          txd_d    = tx_sh_q[1];
        end
      end
      TxStop: if (tx_cnt_q == Div - 1) begin
        tx_cnt_d   = '0;
        tx_state_d = TxIdle;
      end
      default: tx_state_d = TxIdle;
    endcase
    // New events are applied after the serve-clear so a same-cycle event stays pending.
    if (code_vld_q) begin
      if (brk_q) begin
        brk_d = 1'b0;
      end else if (code_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (xl[8]) begin
        key_d     = xl[7:0];
        kb_pend_d = 1'b1;
      end
    end
    if (rx_done) begin
      rx_byte_d = rx_sh_q;
      rx_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps2_sr_q   <= '0;
      ps2_bits_q <= '0;
      ps2_tout_q <= '0;
      code_q     <= '0;
      code_vld_q <= 1'b0;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
      kb_pend_q  <= 1'b0;
      rx_pend_q  <= 1'b0;
      brk_q      <= 1'b0;
      key_q      <= '0;
      rx_byte_q  <= '0;
    end else begin
      ps2_sr_q   <= ps2_sr_d;
      ps2_bits_q <= ps2_bits_d;
      ps2_tout_q <= ps2_tout_d;
      code_q     <= code_d;
      code_vld_q <= code_vld_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
      kb_pend_q  <= kb_pend_d;
      rx_pend_q  <= rx_pend_d;
      brk_q      <= brk_d;
      key_q      <= key_d;
      rx_byte_q  <= rx_byte_d;
    end
  end

  always_comb begin
    nib = key_q[3:0];
    case (dig_q)
      2'd1:    nib = key_q[7:4];
      2'd2:    nib = rx_byte_q[3:0];
      2'd3:    nib = rx_byte_q[7:4];
      default: nib = key_q[3:0];
    endcase
    an_d  = ~(4'b0001 << dig_q);
    seg_d = font(nib);
  end

  assign led      = led_q;
  assign uart_txd = txd_q;
  assign ascii    = key_q;
  assign an_out   = an_q;
  assign seg_out  = seg_q;

endmodule

// File: tb/tb_soc_system.sv
`timescale 1ns / 1ps
// Directed bench for soc_system with scaled clock so DIV = 43 and the heartbeat fits the run.
module tb_soc_system;

  localparam int Clk  = 86000;
  localparam int Baud = 2000;
  localparam int Div  = Clk / Baud;
  localparam int Half = Clk / 2;
  localparam int Ref  = Clk / 1000;

  logic       clk, rst, led, uart_rxd, uart_txd, clkps2, ps2_dat_in;
  logic [7:0] ascii, seg_out;
  logic [3:0] an_out;
  int         n_checks, n_errors, cyc, lows;

  soc_system #(
    .clk_freq      (Clk),
    .uart_baud_rate(Baud)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .led       (led),
    .uart_rxd  (uart_rxd),
    .uart_txd  (uart_txd),
    .ascii     (ascii),
    .clkps2    (clkps2),
    .ps2_dat_in(ps2_dat_in),
    .an_out    (an_out),
    .seg_out   (seg_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat_in = b;
    repeat (3) @(negedge clk);
    clkps2 = 1'b0;
    repeat (3) @(negedge clk);
    clkps2 = 1'b1;
  endtask

  // bad=1 inverts the odd-parity bit
  task automatic ps2_send(input logic [7:0] code, input logic bad);
    logic p;
    p = ~(^code) ^ bad;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    repeat (6) @(negedge clk);
  endtask

  task automatic uart_send(input logic [7:0] d);
    uart_rxd = 1'b0;
    repeat (Div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      repeat (Div) @(negedge clk);
    end
    uart_rxd = 1'b1;
    repeat (Div) @(negedge clk);
  endtask

  task automatic uart_get(output logic [7:0] d, output logic ok);
    int n;
    n  = 0;
    ok = 1'b1;
    d  = '0;
    while (uart_txd && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (uart_txd) begin
      ok = 1'b0;
    end else begin
      repeat (Div / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (Div) @(negedge clk);
        d[i] = uart_txd;
      end
      repeat (Div) @(negedge clk);
      if (!uart_txd) ok = 1'b0;
    end
  endtask

  task automatic get_and_check(input string tag, input logic [7:0] exp);
    logic [7:0] d;
    logic       ok;
    uart_get(d, ok);
    check_val(tag, {23'd0, ok, d}, {23'd0, 1'b1, exp});
  endtask

  task automatic watch_idle(input int cycles, output int nlow);
    nlow = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (!uart_txd) nlow++;
    end
  endtask

  task automatic disp_check(input string tag, input logic [3:0] an, input logic [7:0] seg);
    int n;
    n = 0;
    while (an_out != an && n < 4 * Ref + 8) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, {20'd0, an_out, seg_out}, {20'd0, an, seg});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    uart_rxd   = 1'b1;
    clkps2     = 1'b1;
    ps2_dat_in = 1'b1;
    #80 rst = 1'b0;
    @(negedge clk);
    check_val("rst_led", {31'd0, led}, 0);
    check_val("rst_txd", {31'd0, uart_txd}, 1);
    check_val("rst_ascii", {24'd0, ascii}, 0);
    check_val("rst_an", {28'd0, an_out}, 32'hE);
    check_val("rst_seg", {24'd0, seg_out}, 32'hC0);

    fork
      ps2_send(8'h1C, 1'b0);
      get_and_check("tx_a", 8'h61);
    join
    check_val("ascii_a", {24'd0, ascii}, 32'h61);
    disp_check("an1_a", 4'b1101, 8'h82);
    disp_check("an0_a", 4'b1110, 8'hF9);

    fork
      ps2_send(8'hF0, 1'b0);
      watch_idle(80 + 2 * Div, lows);
    join
    check_val("brk_f0_notx", lows, 0);
    fork
      ps2_send(8'h1C, 1'b0);
      watch_idle(80 + 2 * Div, lows);
    join
    check_val("brk_1c_notx", lows, 0);
    check_val("brk_ascii", {24'd0, ascii}, 32'h61);
    fork
      ps2_send(8'h32, 1'b0);
      get_and_check("tx_b", 8'h62);
    join
    check_val("ascii_b", {24'd0, ascii}, 32'h62);

    fork
      ps2_send(8'h1C, 1'b1);
      watch_idle(80 + 2 * Div, lows);
    join
    check_val("par_notx", lows, 0);
    check_val("par_ascii", {24'd0, ascii}, 32'h62);

    // Abandoned partial frame must be flushed by the inter-edge timeout.
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_dat_in = 1'b1;
    repeat (30) @(negedge clk);
    fork
      ps2_send(8'h29, 1'b0);
      get_and_check("tx_space", 8'h20);
    join
    check_val("ascii_space", {24'd0, ascii}, 32'h20);

    fork
      uart_send(8'h41);
      get_and_check("echo_41", 8'h41);
    join
    disp_check("an3_41", 4'b0111, 8'h99);
    disp_check("an2_41", 4'b1011, 8'hF9);

    uart_rxd = 1'b0;
    @(negedge clk);
    uart_rxd = 1'b1;
    watch_idle(4 * Div, lows);
    check_val("glitch_notx", lows, 0);
    disp_check("an3_glitch", 4'b0111, 8'h99);

    // Both sources become pending while the 'a' echo is still on the line.
    fork
      ps2_send(8'h1C, 1'b0);
      uart_send(8'h5A);
      begin
        repeat (250) @(negedge clk);
        ps2_send(8'h45, 1'b0);
      end
      begin
        get_and_check("prio_0", 8'h61);
        get_and_check("prio_1", 8'h30);
        get_and_check("prio_2", 8'h5A);
      end
    join
    check_val("ascii_0", {24'd0, ascii}, 32'h30);

    while (cyc < Half - 1) @(negedge clk);
    check_val("hb_before", {31'd0, led}, 0);
    @(negedge clk);
    check_val("hb_toggle", {31'd0, led}, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
